// File: rtl/ph_fifo_pkg.sv
// Shared Tube definitions: bus direction encodings and per-register byte modes.
package ph_fifo_pkg;

  localparam logic RDNW_READ  = 1'b1;
  localparam logic RDNW_WRITE = 1'b0;

  typedef enum logic {
    ModeOneByte = 1'b0,
    ModeTwoByte = 1'b1
  } tube_mode_e;

  // Register 3 is the only two-byte register; 1, 2 and 4 are single-byte.
  function automatic tube_mode_e reg_mode(input logic [2:0] reg_num);
    return (reg_num == 3'd3) ? ModeTwoByte : ModeOneByte;
  endfunction

endpackage

// File: rtl/strobe_trail_m.sv
// Trailing-edge strobe detector that latches direction and data while select is high.
module strobe_trail_m #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             select,
  input  logic             rdnw,
  input  logic [WIDTH-1:0] din,
  output logic             commit,
  output logic             rdnw_q,
  output logic [WIDTH-1:0] din_q
);

  logic prev_select_q;
  logic drop_q;

  // A strobe caught by rst/clear stays disarmed until select falls, so it commits nothing.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_select_q <= 1'b0;
      drop_q        <= select;
      rdnw_q        <= 1'b0;
      din_q         <= '0;
    end else begin
      prev_select_q <= select & ~drop_q;
      drop_q        <= drop_q & select;
      if (select) begin
        rdnw_q <= rdnw;
        din_q  <= din;
      end
    end
  end

  assign commit = prev_select_q & ~select;

endmodule

// File: rtl/ph_fifo_m.sv
// Parasite-to-host byte FIFO: parasite pushes on write strobes, host pops on read strobes.
module ph_fifo_m
  import ph_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             two_byte_mode,
  input  logic             p2_select,
  input  logic             p2_rdnw,
  input  logic [WIDTH-1:0] p2_din,
  output logic             p2_not_full,
  input  logic             p1_select,
  input  logic             p1_rdnw,
  output logic [WIDTH-1:0] p1_dout,
  output logic             p1_data_available
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic             p2_commit, p2_rdnw_q;
  logic [WIDTH-1:0] p2_din_q;
  logic             p1_commit, p1_rdnw_q;
  logic             p1_din_unused;

  strobe_trail_m #(
    .WIDTH (WIDTH)
  ) u_p2_trail (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .select (p2_select),
    .rdnw   (p2_rdnw),
    .din    (p2_din),
    .commit (p2_commit),
    .rdnw_q (p2_rdnw_q),
    .din_q  (p2_din_q)
  );

  strobe_trail_m #(
    .WIDTH (1)
  ) u_p1_trail (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .select (p1_select),
    .rdnw   (p1_rdnw),
    .din    (1'b0),
    .commit (p1_commit),
    .rdnw_q (p1_rdnw_q),
    .din_q  (p1_din_unused)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    thr;
  logic             push, pop;

  assign thr = (tube_mode_e'(two_byte_mode) == ModeTwoByte) ? CW'(DEPTH) : CW'(1);

  assign p1_data_available = (count_q >= thr);
  assign p2_not_full       = (count_q < thr);
  assign p1_dout           = mem_q[rd_ptr_q];

  // thr never exceeds DEPTH, so gating on not_full also blocks pushes into a full FIFO.
  assign push = p2_commit & (p2_rdnw_q == RDNW_WRITE) & p2_not_full;
  assign pop  = p1_commit & (p1_rdnw_q == RDNW_READ) & (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CW'(INIT);
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= p2_din_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ph_fifo_m.sv
// Scoreboard bench for ph_fifo_m: directed strobes, queued expected read bytes, flag checks.
module tb_ph_fifo_m;

  logic       clk = 1'b0;
  logic       rst, clear, two_byte_mode;
  logic       p2_select, p2_rdnw, p1_select, p1_rdnw;
  logic [7:0] p2_din, p1_dout;
  logic       p2_not_full, p1_data_available;

  logic       i1_rst, i1_p1_select, i1_p2_select;
  logic [7:0] i1_p1_dout;
  logic       i1_p2_not_full, i1_p1_data_available;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  ph_fifo_m #(.WIDTH(8), .DEPTH(2), .INIT(0)) dut (
    .clk               (clk),
    .rst               (rst),
    .clear             (clear),
    .two_byte_mode     (two_byte_mode),
    .p2_select         (p2_select),
    .p2_rdnw           (p2_rdnw),
    .p2_din            (p2_din),
    .p2_not_full       (p2_not_full),
    .p1_select         (p1_select),
    .p1_rdnw           (p1_rdnw),
    .p1_dout           (p1_dout),
    .p1_data_available (p1_data_available)
  );

  ph_fifo_m #(.WIDTH(8), .DEPTH(2), .INIT(1)) dut_i1 (
    .clk               (clk),
    .rst               (i1_rst),
    .clear             (1'b0),
    .two_byte_mode     (1'b0),
    .p2_select         (i1_p2_select),
    .p2_rdnw           (1'b0),
    .p2_din            (8'h00),
    .p2_not_full       (i1_p2_not_full),
    .p1_select         (i1_p1_select),
    .p1_rdnw           (1'b1),
    .p1_dout           (i1_p1_dout),
    .p1_data_available (i1_p1_data_available)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: while a host read strobe is high, the head byte must equal the queued expectation.
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (p1_select && p1_rdnw) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got %0h, expected none queued", p1_dout);
      end else begin
        check("rd_data", p1_dout, exp_q[0]);
      end
    end else if (mon_prev && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    mon_prev <= p1_select && p1_rdnw;
  end

  task automatic wr(input logic [7:0] b, input int n);
    p2_select = 1'b1; p2_rdnw = 1'b0; p2_din = b;
    repeat (n) @(posedge clk);
    #1 p2_select = 1'b0; p2_din = 8'hxx;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [7:0] e, input int n);
    exp_q.push_back(e);
    p1_select = 1'b1; p1_rdnw = 1'b1;
    repeat (n) @(posedge clk);
    #1 p1_select = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr_rd(input logic [7:0] b, input logic [7:0] e, input int n);
    exp_q.push_back(e);
    p2_select = 1'b1; p2_rdnw = 1'b0; p2_din = b;
    p1_select = 1'b1; p1_rdnw = 1'b1;
    repeat (n) @(posedge clk);
    #1 p2_select = 1'b0; p1_select = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic flags(input string name, input logic av, input logic nf);
    check({name, "_avail"}, {7'd0, p1_data_available}, {7'd0, av});
    check({name, "_not_full"}, {7'd0, p2_not_full}, {7'd0, nf});
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; two_byte_mode = 1'b0;
    p2_select = 1'b0; p2_rdnw = 1'b1; p2_din = 8'h00;
    p1_select = 1'b0; p1_rdnw = 1'b0;
    i1_rst = 1'b1; i1_p1_select = 1'b0; i1_p2_select = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; i1_rst = 1'b0;

    // 1: reset state and single-byte round trip
    flags("rst", 1'b0, 1'b1);
    check("rst_dout", p1_dout, 8'h00);
    wr(8'hA5, 3);
    flags("t1_wr", 1'b1, 1'b0);
    rd(8'hA5, 3);
    flags("t1_rd", 1'b0, 1'b1);

    // 2: two-byte mode thresholds and full discard
    two_byte_mode = 1'b1; #1;
    wr(8'h11, 2);
    flags("t2_one", 1'b0, 1'b1);
    wr(8'h22, 1);
    flags("t2_two", 1'b1, 1'b0);
    wr(8'h33, 2);
    flags("t2_full", 1'b1, 1'b0);
    rd(8'h11, 2);
    rd(8'h22, 1);
    flags("t2_empty", 1'b0, 1'b1);

    // 3: pointer wrap
    for (int i = 1; i <= 6; i++) begin
      wr(8'(i), 1 + (i % 3));
      rd(8'(i), 2);
    end
    two_byte_mode = 1'b0; #1;
    flags("t3_end", 1'b0, 1'b1);

    // 4: simultaneous push and pop at count 1
    two_byte_mode = 1'b1; #1;
    wr(8'h44, 2);
    wr_rd(8'h55, 8'h44, 2);
    flags("t4_m2", 1'b0, 1'b1);
    two_byte_mode = 1'b0; #1;
    flags("t4_m1", 1'b1, 1'b0);
    rd(8'h55, 2);
    flags("t4_end", 1'b0, 1'b1);

    // 5: clear drops an in-progress strobe
    wr(8'h7E, 2);
    flags("t5_wr", 1'b1, 1'b0);
    p2_select = 1'b1; p2_rdnw = 1'b0; p2_din = 8'h99;
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    flags("t5_clr", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 p2_select = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    flags("t5_drop", 1'b0, 1'b1);
    check("t5_dout", p1_dout, 8'h00);

    // 6: INIT=1 instance
    check("i1_avail", {7'd0, i1_p1_data_available}, 8'd1);
    check("i1_not_full", {7'd0, i1_p2_not_full}, 8'd0);
    check("i1_dout", i1_p1_dout, 8'h00);
    i1_p1_select = 1'b1;
    repeat (2) @(posedge clk);
    #1 i1_p1_select = 1'b0;
    @(posedge clk); #1;
    check("i1_rd_avail", {7'd0, i1_p1_data_available}, 8'd0);
    check("i1_rd_not_full", {7'd0, i1_p2_not_full}, 8'd1);

    @(posedge clk); #1;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
